// File: rtl/hilo_muldiv_ctrl_pkg.sv
// ============================================================================
// Module      : hilo_pkg
// Description : Shared types and constants for the HI/LO multiply/divide
//               sequencer. Holds the FSM state encoding, the operation codes
//               and a helper that sizes the iteration counter.
//               Optional feature macro: HILO_DIVZERO_FLAG_EN (see top).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hilo_pkg;

  localparam int HILO_DATA_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // Counter must hold DATA_WIDTH-1; never narrower than one bit.
  function automatic int hilo_cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_if.sv
// ============================================================================
// Module      : hilo_muldiv_ctrl_if
// Description : Bus between the control unit / datapath (master) and the
//               MUL/DIV sequencer (slave).
//   start, op, op_a, op_b      : master -> slave request and operands
//   busy, done                 : slave status
//   HIin, LOin                 : one-cycle HI/LO register enables
//   hi_data, lo_data           : values to load into HI/LO
//   div_zero                   : only with HILO_DIVZERO_FLAG_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hilo_muldiv_ctrl_if
  import hilo_pkg::*;
#(
  parameter int DATA_WIDTH = HILO_DATA_WIDTH
);
  logic                  start;
  logic                  op;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  busy;
  logic                  done;
  logic                  HIin;
  logic                  LOin;
  logic [DATA_WIDTH-1:0] hi_data;
  logic [DATA_WIDTH-1:0] lo_data;
`ifdef HILO_DIVZERO_FLAG_EN
  logic                  div_zero;

  modport master (
    output start, op, op_a, op_b,
    input  busy, done, HIin, LOin, hi_data, lo_data, div_zero
  );
  modport slave (
    input  start, op, op_a, op_b,
    output busy, done, HIin, LOin, hi_data, lo_data, div_zero
  );
`else
  modport master (
    output start, op, op_a, op_b,
    input  busy, done, HIin, LOin, hi_data, lo_data
  );
  modport slave (
    input  start, op, op_a, op_b,
    output busy, done, HIin, LOin, hi_data, lo_data
  );
`endif
endinterface

`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_step.sv
// ============================================================================
// Module      : hilo_iter_step
// Description : Combinational single-bit step of the unsigned MUL/DIV core.
//   op_i     : OP_MUL shift-add, OP_DIV restoring shift-subtract
//   acc_i    : accumulator (upper product half / partial remainder)
//   shreg_i  : shift register (multiplier -> lower product / dividend -> quotient)
//   m_i      : multiplicand / divisor magnitude
//   acc_o, shreg_o : values after one step
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_iter_step
  import hilo_pkg::*;
#(
  parameter int DATA_WIDTH = HILO_DATA_WIDTH
) (
  input  logic                  op_i,
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0] shreg_i,
  input  logic [DATA_WIDTH-1:0] m_i,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic [DATA_WIDTH-1:0] shreg_o
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] rem_sh;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, m_i} : '0);
    rem_sh = {acc_i, shreg_i[DATA_WIDTH-1]};
    diff   = rem_sh - {1'b0, m_i};
    acc_o   = acc_i;
    shreg_o = shreg_i;
    if (op_i == OP_MUL) begin
      // The carry-out of the add shifts into the accumulator MSB.
      acc_o   = sum[DATA_WIDTH:1];
      shreg_o = {sum[0], shreg_i[DATA_WIDTH-1:1]};
    end else if (!diff[DATA_WIDTH]) begin
      // No borrow: the shifted remainder covers the divisor.
      acc_o   = diff[DATA_WIDTH-1:0];
      shreg_o = {shreg_i[DATA_WIDTH-2:0], 1'b1};
    end else begin
      acc_o   = rem_sh[DATA_WIDTH-1:0];
      shreg_o = {shreg_i[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
// ============================================================================
// Module      : hilo_muldiv_ctrl
// Description : Multi-cycle signed MUL/DIV sequencer owning the HI/LO write
//               path. One bit per clock; result written through one-cycle
//               HIin/LOin strobes.
//   clock    : rising-edge clock
//   clear    : synchronous active-high reset, overrides everything
//   bus      : hilo_muldiv_ctrl_if.slave (start/op/op_a/op_b in,
//              busy/done/HIin/LOin/hi_data/lo_data[/div_zero] out)
// Macro       : HILO_DIVZERO_FLAG_EN - divide by zero is short-circuited
//               and flagged on div_zero instead of writing HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int DATA_WIDTH = HILO_DATA_WIDTH
) (
  input logic                clock,
  input logic                clear,
  hilo_muldiv_ctrl_if.slave  bus
);

  localparam int CNT_W = hilo_cnt_width(DATA_WIDTH);

  state_t                  state_q;
  logic                    op_q;
  logic [DATA_WIDTH-1:0]   opa_q;
  logic [DATA_WIDTH-1:0]   opb_q;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [DATA_WIDTH-1:0]   m_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    neg_res_q;
  logic                    neg_rem_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   hi_q;
  logic [DATA_WIDTH-1:0]   lo_q;
`ifdef HILO_DIVZERO_FLAG_EN
  logic                    dz_q;
`endif

  logic [DATA_WIDTH-1:0]   acc_d;
  logic [DATA_WIDTH-1:0]   shreg_d;
  logic [DATA_WIDTH-1:0]   fix_hi_d;
  logic [DATA_WIDTH-1:0]   fix_lo_d;
  logic [2*DATA_WIDTH-1:0] prod;

  hilo_iter_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .op_i    (op_q),
    .acc_i   (acc_q),
    .shreg_i (shreg_q),
    .m_i     (m_q),
    .acc_o   (acc_d),
    .shreg_o (shreg_d)
  );

  // Sign fix-up of the unsigned core result.
  always_comb begin
    prod     = {acc_q, shreg_q};
    fix_hi_d = '0;
    fix_lo_d = '0;
    if (op_q == OP_MUL) begin
      if (neg_res_q) prod = -prod;
      {fix_hi_d, fix_lo_d} = prod;
    end else begin
      fix_lo_d = neg_res_q ? -shreg_q : shreg_q;
      fix_hi_d = neg_rem_q ? -acc_q : acc_q;
`ifndef HILO_DIVZERO_FLAG_EN
      if (opb_q == '0) begin
        fix_lo_d = '1;
        fix_hi_d = opa_q;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      shreg_q   <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef HILO_DIVZERO_FLAG_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
`ifdef HILO_DIVZERO_FLAG_EN
      dz_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            opa_q   <= bus.op_a;
            opb_q   <= bus.op_b;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          acc_q     <= '0;
          shreg_q   <= opa_q[DATA_WIDTH-1] ? -opa_q : opa_q;
          m_q       <= opb_q[DATA_WIDTH-1] ? -opb_q : opb_q;
          cnt_q     <= CNT_W'(DATA_WIDTH - 1);
          neg_res_q <= opa_q[DATA_WIDTH-1] ^ opb_q[DATA_WIDTH-1];
          neg_rem_q <= opa_q[DATA_WIDTH-1];
          state_q   <= ST_ITER;
`ifdef HILO_DIVZERO_FLAG_EN
          // Divide by zero skips the iteration and leaves HI/LO untouched.
          if (op_q == OP_DIV && opb_q == '0) begin
            done_q  <= 1'b1;
            dz_q    <= 1'b1;
            state_q <= ST_WRITE;
          end
`endif
        end
        ST_ITER: begin
          acc_q   <= acc_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= ST_FIXUP;
        end
        ST_FIXUP: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          done_q  <= 1'b1;
          we_q    <= 1'b1;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.HIin    = we_q;
  assign bus.LOin    = we_q;
  assign bus.hi_data = hi_q;
  assign bus.lo_data = lo_q;
`ifdef HILO_DIVZERO_FLAG_EN
  assign bus.div_zero = dz_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
// ============================================================================
// Module      : tb_hilo_muldiv_ctrl
// Description : Self-checking bench for hilo_muldiv_ctrl. Directed and
//               random MUL/DIV operations compared against a plain
//               arithmetic model; includes clear abort and held-start cases.
//               Honours HILO_DIVZERO_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_ctrl;

  localparam int W   = 32;
  localparam int LAT = W + 3;

  logic clock;
  logic clear;
  int   checks;
  int   errors;

  logic [W-1:0] hi_reg;
  logic [W-1:0] lo_reg;

  hilo_muldiv_ctrl_if #(.DATA_WIDTH(W)) bus ();

  hilo_muldiv_ctrl #(.DATA_WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers.
  task automatic model(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] ehi, output logic [W-1:0] elo,
                       output int elat, output bit ewe, output bit edz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    elat = LAT; ewe = 1'b1; edz = 1'b0;
    ehi = hi_reg; elo = lo_reg;
    if (!op) begin
      p = sa * sb;
      ehi = p[63:32];
      elo = p[31:0];
    end else if (b == '0) begin
`ifdef HILO_DIVZERO_FLAG_EN
      elat = 2; ewe = 1'b0; edz = 1'b1;
`else
      ehi = a;
      elo = '1;
`endif
    end else begin
      q = sa / sb;
      r = sa % sb;
      ehi = r[31:0];
      elo = q[31:0];
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // IDLE cycle following WRITE.
  task automatic run_op(input bit op, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    logic [W-1:0] ehi, elo;
    int  elat;
    bit  ewe, edz;
    int  done_cyc, busy_cnt, done_cnt, we_cnt, dz_cnt, skew;
    model(op, a, b, ehi, elo, elat, ewe, edz);
    done_cyc = 0; busy_cnt = 0; done_cnt = 0; we_cnt = 0; dz_cnt = 0; skew = 0;
    bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
    @(posedge clock);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (!hold) bus.start = 1'b0;
      bus.op   = 1'($urandom);
      bus.op_a = $urandom;
      bus.op_b = $urandom;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (bus.HIin) begin
        we_cnt++;
        hi_reg = bus.hi_data;
      end
      if (bus.LOin) lo_reg = bus.lo_data;
      if (bus.HIin !== bus.LOin) skew++;
`ifdef HILO_DIVZERO_FLAG_EN
      if (bus.div_zero) dz_cnt++;
`endif
      if (done_cyc != 0 && !bus.busy) break;
    end
    check("latency", 64'(done_cyc), 64'(elat));
    check("busy_cycles", 64'(busy_cnt), 64'(elat));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("we_pulses", 64'(we_cnt), 64'(ewe));
    check("hi_lo_skew", 64'(skew), 64'd0);
`ifdef HILO_DIVZERO_FLAG_EN
    check("div_zero_pulses", 64'(dz_cnt), 64'(edz));
`endif
    check("HI", 64'(hi_reg), 64'(ehi));
    check("LO", 64'(lo_reg), 64'(elo));
    if (ewe) begin
      check("hi_data_hold", 64'(bus.hi_data), 64'(ehi));
      check("lo_data_hold", 64'(bus.lo_data), 64'(elo));
    end
  endtask

  initial begin
    int we_cnt_c;
    logic [W-1:0] ra, rb;
    checks = 0; errors = 0;
    hi_reg = '0; lo_reg = '0;
    clear = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_HIin", 64'(bus.HIin), 64'd0);
    check("rst_LOin", 64'(bus.LOin), 64'd0);
    check("rst_hi_data", 64'(bus.hi_data), 64'd0);
    check("rst_lo_data", 64'(bus.lo_data), 64'd0);
`ifdef HILO_DIVZERO_FLAG_EN
    check("rst_div_zero", 64'(bus.div_zero), 64'd0);
`endif
    @(negedge clock);

    // Directed cases
    run_op(1'b0, 32'd7, 32'd5, 1'b0);
    run_op(1'b0, 32'hFFFFFFFD, 32'd5, 1'b0);
    run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 1'b0);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(1'b1, 32'd9, 32'd0, 1'b0);
    run_op(1'b0, 32'd123456, 32'hFFFF0001, 1'b0);

    // Start held high over a whole op, then immediately the next one
    run_op(1'b0, 32'd1000, 32'hFFFFFF00, 1'b1);
    run_op(1'b1, 32'hFFFF8000, 32'd37, 1'b0);

    // Clear mid-operation
    we_cnt_c = 0;
    bus.start = 1'b1; bus.op = 1'b0; bus.op_a = 32'd77; bus.op_b = 32'd99;
    @(posedge clock);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (n == 10) clear = 1'b1;
      if (n == 11) begin
        clear = 1'b0;
        check("clr_busy", 64'(bus.busy), 64'd0);
        check("clr_hi_data", 64'(bus.hi_data), 64'd0);
        check("clr_lo_data", 64'(bus.lo_data), 64'd0);
      end
      if (bus.HIin || bus.LOin || bus.done) we_cnt_c++;
    end
    check("clr_no_write", 64'(we_cnt_c), 64'd0);
    run_op(1'b0, 32'd6, 32'hFFFFFFF9, 1'b0);

    // Random operations
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 32'h80000000;
        1:       ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = $urandom_range(1, 15);
        3:       rb = -($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(1'($urandom_range(0, 1)), ra, rb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
